pc_gen: RTL and testbench

- Parametrised successor to the single-register fetch PC.
- Holds the fetch PC and handshakes PCs to IF with valid/ready.
- Arbitrates two redirect sources by priority: EX mispredict/jump, then ID early jump.
- Records each issued PC with its prediction in a small fetch-target queue (FTQ), which downstream drains or flushes.

---
 rtl/pc_gen_pkg.sv | 20 ++
 rtl/pc_gen_ftq.sv | 103 ++++++++++
 rtl/pc_gen.sv | 121 ++++++++++++
 tb/tb_pc_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator and its fetch-target queue.
package pc_gen_pkg;

    localparam int unsigned PC_GEN_ADDR_W = 32;
    localparam logic [PC_GEN_ADDR_W-1:0] PC_GEN_RESET_PC = '0;

    // What the PC register does this cycle, highest-priority source wins.
    typedef enum logic [1:0] {
        PC_HOLD,
        PC_EX_REDIR,
        PC_ID_REDIR,
        PC_ACCEPT
    } pc_action_e;

    // FTQ entry layout is {pc, pred_pc, taken}: two addresses plus one flag.
    function automatic int unsigned ftq_entry_width(input int unsigned addr_w);
        return 2 * addr_w + 1;
    endfunction

endpackage

// File: rtl/pc_gen_ftq.sv
// Fetch-target queue: circular FIFO of issued PCs with flush and
// truncate-to-oldest-entry controls. Pointers wrap modulo FTQ_DEPTH;
// occupancy is tracked by a separate counter so full/empty are unambiguous.
module pc_gen_ftq
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = PC_GEN_ADDR_W,
    parameter int unsigned FTQ_DEPTH = 4,
    parameter int unsigned CNT_W     = $clog2(FTQ_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              truncate,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [ADDR_W-1:0] push_pred_pc,
    input  logic              push_taken,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_pc,
    output logic [ADDR_W-1:0] head_pred_pc,
    output logic              head_taken,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W   = $clog2(FTQ_DEPTH);
    localparam int unsigned ENTRY_W = ftq_entry_width(ADDR_W);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pred_pc;
        logic              taken;
    } entry_t;

    logic [ENTRY_W-1:0] mem [FTQ_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic               pop_ok;
    logic               push_ok;
    entry_t             head_entry;
    entry_t             push_entry;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FTQ_DEPTH));
    assign count   = count_q;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !full && !flush && !truncate;

    assign push_entry   = '{pc: push_pc, pred_pc: push_pred_pc, taken: push_taken};
    assign head_entry   = entry_t'(mem[head]);
    assign head_pc      = head_entry.pc;
    assign head_pred_pc = head_entry.pred_pc;
    assign head_taken   = head_entry.taken;

    // Pointer and occupancy update: flush beats truncate beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (en) begin
            if (flush) begin
                head    <= tail;
                count_q <= '0;
            end else if (truncate) begin
                // Keep only the oldest entry; a same-cycle pop then retires it.
                if (!empty) begin
                    tail <= head + PTR_W'(1);
                    if (pop) begin
                        head    <= head + PTR_W'(1);
                        count_q <= '0;
                    end else begin
                        count_q <= CNT_W'(1);
                    end
                end
            end else begin
                if (push_ok) begin
                    tail <= tail + PTR_W'(1);
                end
                if (pop_ok) begin
                    head <= head + PTR_W'(1);
                end
                if (push_ok && !pop_ok) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (!push_ok && pop_ok) begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
        end
    end

    // Entry storage; contents are don't-care until written so no reset.
    always_ff @(posedge clk) begin
        if (!rst && en && push_ok) begin
            mem[tail] <= push_entry;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: holds the fetch PC, offers it to IF with valid/ready,
// arbitrates EX over ID redirects, and records issued PCs in the FTQ.
// Optional statistics counters are enabled by defining PC_GEN_STATS_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W    = PC_GEN_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(PC_GEN_RESET_PC),
    parameter int unsigned       FTQ_DEPTH = 4,
    parameter int unsigned       CNT_W     = $clog2(FTQ_DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              ex_redirect_in,
    input  logic [ADDR_W-1:0] ex_target_in,
    input  logic              id_redirect_in,
    input  logic [ADDR_W-1:0] id_target_in,
    input  logic [ADDR_W-1:0] pred_next_pc_in,
    input  logic              pred_taken_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid_out,
    input  logic              if_ready_in,
    output logic [ADDR_W-1:0] pred_next_pc_out,
    output logic              pred_taken_out,
    input  logic              ftq_pop_in,
    output logic [ADDR_W-1:0] ftq_head_pc_out,
    output logic [ADDR_W-1:0] ftq_head_pred_pc_out,
    output logic              ftq_head_taken_out,
    output logic [CNT_W-1:0]  ftq_count_out,
    output logic              ftq_empty_out
`ifdef PC_GEN_STATS_EN
    ,
    output logic [31:0]       ex_redirect_cnt_out,
    output logic [31:0]       id_redirect_cnt_out,
    output logic [31:0]       full_stall_cnt_out
`endif
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    pc_action_e        action;
    logic              ftq_full;
    logic              accept;

    assign pc_out           = pc_q;
    assign pc_valid_out     = !ftq_full;
    assign pred_next_pc_out = pred_next_pc_in;
    assign pred_taken_out   = pred_taken_in;
    assign accept           = (action == PC_ACCEPT);

    // Pick this cycle's PC source by priority and form the next PC.
    always_comb begin
        action = PC_HOLD;
        pc_d   = pc_q;
        if (ex_redirect_in) begin
            action = PC_EX_REDIR;
            pc_d   = ex_target_in;
        end else if (id_redirect_in) begin
            action = PC_ID_REDIR;
            pc_d   = id_target_in;
        end else if (pc_valid_out && if_ready_in) begin
            action = PC_ACCEPT;
            pc_d   = pred_next_pc_in;
        end
    end

    // Fetch PC register; rdy_in low freezes it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q <= RESET_PC;
        end else if (rdy_in) begin
            pc_q <= pc_d;
        end
    end

    pc_gen_ftq #(
        .ADDR_W    (ADDR_W),
        .FTQ_DEPTH (FTQ_DEPTH),
        .CNT_W     (CNT_W)
    ) u_ftq (
        .clk          (clk_in),
        .rst          (rst_in),
        .en           (rdy_in),
        .flush        (action == PC_EX_REDIR),
        .truncate     (action == PC_ID_REDIR),
        .push         (accept),
        .push_pc      (pc_q),
        .push_pred_pc (pred_next_pc_in),
        .push_taken   (pred_taken_in),
        .pop          (ftq_pop_in),
        .head_pc      (ftq_head_pc_out),
        .head_pred_pc (ftq_head_pred_pc_out),
        .head_taken   (ftq_head_taken_out),
        .count        (ftq_count_out),
        .empty        (ftq_empty_out),
        .full         (ftq_full)
    );

`ifdef PC_GEN_STATS_EN
    // Saturating event counters for applied redirects and full-queue stalls.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ex_redirect_cnt_out <= '0;
            id_redirect_cnt_out <= '0;
            full_stall_cnt_out  <= '0;
        end else if (rdy_in) begin
            if (action == PC_EX_REDIR && ex_redirect_cnt_out != '1) begin
                ex_redirect_cnt_out <= ex_redirect_cnt_out + 32'd1;
            end
            if (action == PC_ID_REDIR && id_redirect_cnt_out != '1) begin
                id_redirect_cnt_out <= id_redirect_cnt_out + 32'd1;
            end
            if (ftq_full && if_ready_in && full_stall_cnt_out != '1) begin
                full_stall_cnt_out <= full_stall_cnt_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a cycle-level reference model drives the
// predictor inputs, and a scoreboard queue holds the expected FTQ contents.
module tb_pc_gen;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] pred;
        logic          taken;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b0;
    logic          ex_redirect_in = 1'b0;
    logic [AW-1:0] ex_target_in = '0;
    logic          id_redirect_in = 1'b0;
    logic [AW-1:0] id_target_in = '0;
    logic [AW-1:0] pred_next_pc_in = '0;
    logic          pred_taken_in = 1'b0;
    logic [AW-1:0] pc_out;
    logic          pc_valid_out;
    logic          if_ready_in = 1'b0;
    logic [AW-1:0] pred_next_pc_out;
    logic          pred_taken_out;
    logic          ftq_pop_in = 1'b0;
    logic [AW-1:0] ftq_head_pc_out;
    logic [AW-1:0] ftq_head_pred_pc_out;
    logic          ftq_head_taken_out;
    logic [CW-1:0] ftq_count_out;
    logic          ftq_empty_out;
`ifdef PC_GEN_STATS_EN
    logic [31:0]   ex_redirect_cnt_out;
    logic [31:0]   id_redirect_cnt_out;
    logic [31:0]   full_stall_cnt_out;
    int unsigned   m_ex_cnt = 0;
    int unsigned   m_id_cnt = 0;
    int unsigned   m_fs_cnt = 0;
`endif

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    ent_t          sb[$];
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] pred_step = 32'd4;
    logic          m_live = 1'b0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W    (AW),
        .RESET_PC  (32'h0),
        .FTQ_DEPTH (DEPTH)
    ) dut (
        .clk_in               (clk),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .ex_redirect_in       (ex_redirect_in),
        .ex_target_in         (ex_target_in),
        .id_redirect_in       (id_redirect_in),
        .id_target_in         (id_target_in),
        .pred_next_pc_in      (pred_next_pc_in),
        .pred_taken_in        (pred_taken_in),
        .pc_out               (pc_out),
        .pc_valid_out         (pc_valid_out),
        .if_ready_in          (if_ready_in),
        .pred_next_pc_out     (pred_next_pc_out),
        .pred_taken_out       (pred_taken_out),
        .ftq_pop_in           (ftq_pop_in),
        .ftq_head_pc_out      (ftq_head_pc_out),
        .ftq_head_pred_pc_out (ftq_head_pred_pc_out),
        .ftq_head_taken_out   (ftq_head_taken_out),
        .ftq_count_out        (ftq_count_out),
        .ftq_empty_out        (ftq_empty_out)
`ifdef PC_GEN_STATS_EN
        ,
        .ex_redirect_cnt_out  (ex_redirect_cnt_out),
        .id_redirect_cnt_out  (id_redirect_cnt_out),
        .full_stall_cnt_out   (full_stall_cnt_out)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check settled outputs against the model,
    // advance the model as the design should, then let the edge happen.
    task automatic cycle(input logic rst, input logic rdy, input logic ex,
                         input logic [AW-1:0] ext, input logic id,
                         input logic [AW-1:0] idt, input logic ifr, input logic pop);
        logic          full;
        logic          accept;
        logic [AW-1:0] pn;
        logic          pt;
        ent_t          e;
        pn = m_pc + pred_step;
        pt = m_pc[2];
        rst_in = rst; rdy_in = rdy; ex_redirect_in = ex; ex_target_in = ext;
        id_redirect_in = id; id_target_in = idt; if_ready_in = ifr; ftq_pop_in = pop;
        pred_next_pc_in = pn; pred_taken_in = pt;
        #2;
        full = (sb.size() == DEPTH);
        if (m_live) begin
            check("pc", 64'(pc_out), 64'(m_pc));
            check("valid", 64'(pc_valid_out), 64'(!full));
            check("count", 64'(ftq_count_out), 64'(sb.size()));
            check("empty", 64'(ftq_empty_out), 64'(sb.size() == 0));
            check("pt_pc", 64'(pred_next_pc_out), 64'(pn));
            check("pt_taken", 64'(pred_taken_out), 64'(pt));
            if (sb.size() > 0) begin
                check("head_pc", 64'(ftq_head_pc_out), 64'(sb[0].pc));
                check("head_pred", 64'(ftq_head_pred_pc_out), 64'(sb[0].pred));
                check("head_taken", 64'(ftq_head_taken_out), 64'(sb[0].taken));
            end
`ifdef PC_GEN_STATS_EN
            check("ex_cnt", 64'(ex_redirect_cnt_out), 64'(m_ex_cnt));
            check("id_cnt", 64'(id_redirect_cnt_out), 64'(m_id_cnt));
            check("fs_cnt", 64'(full_stall_cnt_out), 64'(m_fs_cnt));
`endif
        end
        if (rst) begin
            m_pc = '0;
            sb.delete();
            m_live = 1'b1;
`ifdef PC_GEN_STATS_EN
            m_ex_cnt = 0; m_id_cnt = 0; m_fs_cnt = 0;
`endif
        end else if (rdy) begin
`ifdef PC_GEN_STATS_EN
            if (full && ifr) m_fs_cnt++;
`endif
            accept = !full && ifr && !ex && !id;
            if (ex) begin
                m_pc = ext;
                sb.delete();
`ifdef PC_GEN_STATS_EN
                m_ex_cnt++;
`endif
            end else if (id) begin
                m_pc = idt;
                while (sb.size() > 1) void'(sb.pop_back());
                if (pop && sb.size() > 0) void'(sb.pop_front());
`ifdef PC_GEN_STATS_EN
                m_id_cnt++;
`endif
            end else begin
                if (pop && sb.size() > 0) void'(sb.pop_front());
                if (accept) begin
                    e = '{pc: m_pc, pred: pn, taken: pt};
                    sb.push_back(e);
                    m_pc = pn;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then fill the FTQ with a pc+4 predictor.
        cycle(1, 1, 0, '0, 0, '0, 0, 0);
        repeat (4) cycle(0, 1, 0, '0, 0, '0, 1, 0);
        repeat (2) cycle(0, 1, 0, '0, 0, '0, 1, 0);
        cycle(0, 1, 0, '0, 0, '0, 1, 1);
        cycle(0, 1, 0, '0, 0, '0, 1, 0);
        cycle(0, 1, 0, '0, 0, '0, 0, 1);
        // EX redirect with simultaneous pop and ready flushes everything.
        cycle(0, 1, 1, 32'h100, 0, '0, 1, 1);
        repeat (2) cycle(0, 1, 0, '0, 0, '0, 1, 0);
        // EX and ID together: EX wins.
        cycle(0, 1, 1, 32'h200, 1, 32'h300, 1, 0);
        cycle(0, 1, 0, '0, 0, '0, 0, 0);
        // ID truncation to the oldest entry, then with pop, then when empty.
        cycle(0, 1, 1, 32'h20, 0, '0, 0, 0);
        repeat (3) cycle(0, 1, 0, '0, 0, '0, 1, 0);
        cycle(0, 1, 0, '0, 1, 32'h80, 1, 0);
        repeat (2) cycle(0, 1, 0, '0, 0, '0, 1, 0);
        cycle(0, 1, 0, '0, 1, 32'h90, 1, 1);
        cycle(0, 1, 0, '0, 1, 32'hA0, 0, 1);
        repeat (2) cycle(0, 1, 0, '0, 0, '0, 1, 0);
        // Global freeze.
        repeat (5) cycle(0, 0, 1, 32'h400, 0, '0, 1, 1);
        repeat (3) cycle(0, 1, 0, '0, 0, '0, 1, 1);
        // Pointer wrap with continuous push/pop from reset, then drain past empty.
        cycle(1, 1, 0, '0, 0, '0, 0, 0);
        repeat (10) cycle(0, 1, 0, '0, 0, '0, 1, 1);
        repeat (3) cycle(0, 1, 0, '0, 0, '0, 0, 1);
        // Reset overrides redirects and pops.
        cycle(1, 1, 1, 32'h500, 1, 32'h600, 1, 1);
        cycle(0, 1, 0, '0, 0, '0, 0, 0);
        // Random mix.
        for (int i = 0; i < 400; i++) begin
            pred_step = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            cycle(($urandom % 97) == 0, ($urandom % 8) != 0,
                  ($urandom % 12) == 0, $urandom & 32'hFFFF_FFFC,
                  ($urandom % 10) == 0, $urandom & 32'hFFFF_FFFC,
                  ($urandom % 4) != 0, ($urandom % 3) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
